// File: rtl/vga_scan_out.sv
// VGA raster generator and output stage: free-running h/v counters feed the tile
// controller, and returned pixel colour is aligned with delayed sync/blank controls.
module vga_scan_out #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  input  logic [7:0] pixel_data,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS       = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS       = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic active_s;
  logic hs_raw_s;
  logic vs_raw_s;
  logic fs_raw_s;

  logic [READ_LATENCY-1:0] act_pipe_r;
  logic [READ_LATENCY-1:0] hs_pipe_r;
  logic [READ_LATENCY-1:0] vs_pipe_r;
  logic [READ_LATENCY-1:0] fs_pipe_r;

  // Raster counters; the frame origin (0,0) is visited exactly once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= 10'd0;
      v_count <= 10'd0;
    end else if (h_count == H_LAST) begin
      h_count <= 10'd0;
      if (v_count == V_LAST) begin
        v_count <= 10'd0;
      end else begin
        v_count <= v_count + 10'd1;
      end
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  // Timing decode from the current raster position.
  always_comb begin
    active_s = (h_count < H_VIS) && (v_count < V_VIS);
    hs_raw_s = !((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
    vs_raw_s = !((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
    fs_raw_s = (h_count == 10'd0) && (v_count == 10'd0);
  end

  // Delay controls by the controller read latency so they meet pixel_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_pipe_r <= {READ_LATENCY{1'b0}};
      hs_pipe_r  <= {READ_LATENCY{1'b1}};
      vs_pipe_r  <= {READ_LATENCY{1'b1}};
      fs_pipe_r  <= {READ_LATENCY{1'b0}};
    end else begin
      act_pipe_r[0] <= active_s;
      hs_pipe_r[0]  <= hs_raw_s;
      vs_pipe_r[0]  <= vs_raw_s;
      fs_pipe_r[0]  <= fs_raw_s;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        act_pipe_r[i] <= act_pipe_r[i-1];
        hs_pipe_r[i]  <= hs_pipe_r[i-1];
        vs_pipe_r[i]  <= vs_pipe_r[i-1];
        fs_pipe_r[i]  <= fs_pipe_r[i-1];
      end
    end
  end

  // Output register: RGB332 expanded to 4 bits per channel by MSB replication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (act_pipe_r[READ_LATENCY-1]) begin
        vga_r <= {pixel_data[7:5], pixel_data[7]};
        vga_g <= {pixel_data[4:2], pixel_data[4]};
        vga_b <= {pixel_data[1:0], pixel_data[1:0]};
      end else begin
        vga_r <= 4'h0;
        vga_g <= 4'h0;
        vga_b <= 4'h0;
      end
      vga_hs      <= hs_pipe_r[READ_LATENCY-1];
      vga_vs      <= vs_pipe_r[READ_LATENCY-1];
      frame_start <= fs_pipe_r[READ_LATENCY-1];
    end
  end

endmodule
